// File: rtl/coin_acceptor.sv
// Coin acceptor front end.
// Collects coins against a latched cost in nickel units and keeps the
// quarter/dime/nickel inventory that the change logic draws from.
// It signals done when the cost is met, refund on cancel or timeout,
// and reject when a coin cannot be taken.
module coin_acceptor #(
    parameter int AMT_W   = 4,
    parameter int INV_MAX = 3,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AMT_W-1:0] cost,
    input  logic             coin_valid,
    input  logic [1:0]       coin_type,
    input  logic             cancel,
    input  logic             disp_valid,
    input  logic [2:0]       disp_coin,
    output logic             busy,
    output logic [AMT_W-1:0] paid,
    output logic             coin_accept,
    output logic             coin_reject,
    output logic             done,
    output logic             refund,
    output logic             cough_up_more,
    output logic [1:0]       quarters,
    output logic [1:0]       dimes,
    output logic [1:0]       nickels
);

    typedef enum logic [1:0] {IDLE, COLLECT, DONE, REFUND} state_t;

    localparam int INV_W = 2;
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [INV_W-1:0] INV_FULL = INV_W'(INV_MAX);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [AMT_W:0]   AMT_MAX  = {1'b0, {AMT_W{1'b1}}};

    // Inventory and per-transaction counts indexed 0=nickel, 1=dime, 2=quarter.
    state_t             state_reg;
    logic [AMT_W-1:0]   cost_reg;
    logic [AMT_W-1:0]   paid_reg;
    logic [TMR_W-1:0]   timer_reg;
    logic [INV_W-1:0]   inv_reg [0:2];
    logic [INV_W-1:0]   tx_reg  [0:2];
    logic               busy_reg;
    logic               coin_accept_reg;
    logic               coin_reject_reg;
    logic               done_reg;
    logic               refund_reg;
    logic               cough_reg;

    logic [2:0]         coin_val;
    logic [1:0]         coin_idx;
    logic               coin_legal;
    logic [1:0]         disp_idx;
    logic               disp_legal;
    logic [AMT_W:0]     sum;
    logic               can_accept;

    // Decode the presented coin and the dispensed coin into value and slot.
    always_comb begin
        coin_val   = 3'd0;
        coin_idx   = 2'd0;
        coin_legal = 1'b0;
        case (coin_type)
            2'b01:   begin coin_val = 3'd1; coin_idx = 2'd0; coin_legal = 1'b1; end
            2'b10:   begin coin_val = 3'd2; coin_idx = 2'd1; coin_legal = 1'b1; end
            2'b11:   begin coin_val = 3'd5; coin_idx = 2'd2; coin_legal = 1'b1; end
            default: begin coin_val = 3'd0; coin_idx = 2'd0; coin_legal = 1'b0; end
        endcase
        disp_idx   = 2'd0;
        disp_legal = 1'b0;
        case (disp_coin)
            3'd1:    begin disp_idx = 2'd0; disp_legal = 1'b1; end
            3'd2:    begin disp_idx = 2'd1; disp_legal = 1'b1; end
            3'd5:    begin disp_idx = 2'd2; disp_legal = 1'b1; end
            default: begin disp_idx = 2'd0; disp_legal = 1'b0; end
        endcase
    end

    // One extra bit on the sum so an overflowing coin is seen rather than wrapped.
    assign sum        = {1'b0, paid_reg} + (AMT_W + 1)'(coin_val);
    assign can_accept = coin_legal && (inv_reg[coin_idx] < INV_FULL) && (sum <= AMT_MAX);

    // Transaction FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            cost_reg        <= '0;
            paid_reg        <= '0;
            timer_reg       <= '0;
            busy_reg        <= 1'b0;
            coin_accept_reg <= 1'b0;
            coin_reject_reg <= 1'b0;
            done_reg        <= 1'b0;
            refund_reg      <= 1'b0;
            cough_reg       <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                inv_reg[i] <= '0;
                tx_reg[i]  <= '0;
            end
        end else begin
            coin_accept_reg <= 1'b0;
            coin_reject_reg <= 1'b0;
            done_reg        <= 1'b0;
            refund_reg      <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (disp_valid && disp_legal && (inv_reg[disp_idx] != '0))
                        inv_reg[disp_idx] <= inv_reg[disp_idx] - INV_W'(1);
                    if (start) begin
                        cost_reg  <= cost;
                        paid_reg  <= '0;
                        timer_reg <= '0;
                        busy_reg  <= 1'b1;
                        for (int i = 0; i < 3; i++)
                            tx_reg[i] <= '0;
                        if (cost == '0) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                            cough_reg <= 1'b0;
                        end else begin
                            state_reg <= COLLECT;
                            cough_reg <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (cancel) begin
                        state_reg  <= REFUND;
                        refund_reg <= 1'b1;
                        cough_reg  <= 1'b0;
                        if (coin_valid)
                            coin_reject_reg <= 1'b1;
                    end else if (coin_valid) begin
                        timer_reg <= '0;
                        if (can_accept) begin
                            paid_reg          <= sum[AMT_W-1:0];
                            inv_reg[coin_idx] <= inv_reg[coin_idx] + INV_W'(1);
                            tx_reg[coin_idx]  <= tx_reg[coin_idx] + INV_W'(1);
                            coin_accept_reg   <= 1'b1;
                            if (sum[AMT_W-1:0] >= cost_reg) begin
                                state_reg <= DONE;
                                done_reg  <= 1'b1;
                                cough_reg <= 1'b0;
                            end
                        end else begin
                            coin_reject_reg <= 1'b1;
                        end
                    end else if (timer_reg == TMR_LAST) begin
                        state_reg  <= REFUND;
                        refund_reg <= 1'b1;
                        cough_reg  <= 1'b0;
                    end else begin
                        timer_reg <= timer_reg + TMR_W'(1);
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                REFUND: begin
                    // Coins of this transaction go back to the customer.
                    for (int i = 0; i < 3; i++)
                        inv_reg[i] <= inv_reg[i] - tx_reg[i];
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy          = busy_reg;
    assign paid          = paid_reg;
    assign coin_accept   = coin_accept_reg;
    assign coin_reject   = coin_reject_reg;
    assign done          = done_reg;
    assign refund        = refund_reg;
    assign cough_up_more = cough_reg;
    assign nickels       = inv_reg[0];
    assign dimes         = inv_reg[1];
    assign quarters      = inv_reg[2];

endmodule

// File: doc/coin_acceptor.md
Name: coin_acceptor

Overview:
Front end of the vending/change path. It accepts coins from the customer one per cycle and accumulates the paid amount in nickel units against a latched cost. It maintains the quarter/dime/nickel inventory that the change logic draws from, and signals completion, refund on cancel/timeout, or coin rejection. In IDLE it also applies coin-dispense decrements issued by the change logic, so inventory stays coherent.

Parameters:
AMT_W, 4, width of cost/paid in nickel units (max 15)
INV_MAX, 3, per-type inventory capacity (2-bit counters)
TIMEOUT, 15, COLLECT cycles with no coin_valid before auto-refund

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  begin transaction; sampled only in IDLE
cost  in  AMT_W  price in nickels; latched on accepted start
coin_valid  in  1  a coin is presented this cycle
coin_type  in  2  01=nickel(1), 10=dime(2), 11=quarter(5), 00=illegal
cancel  in  1  customer abort
disp_valid  in  1  change logic removed one coin; honoured only in IDLE
disp_coin  in  3  value of removed coin: 1, 2 or 5 nickels
busy  out  1  high in COLLECT, DONE, REFUND
paid  out  AMT_W  accumulated amount of current/last transaction
coin_accept  out  1  1-cycle pulse, coin taken
coin_reject  out  1  1-cycle pulse, coin returned
done  out  1  1-cycle pulse, paid >= cost
refund  out  1  1-cycle pulse, return paid to customer
cough_up_more  out  1  high in COLLECT while paid < cost
quarters, dimes, nickels  out  2 each  current inventory

Behaviour:
- Reset: state IDLE; paid=0, inventory=0, timeout counter=0, all pulses and busy=0, cough_up_more=0, latched cost=0. Reset mid-transaction abandons it with no refund pulse.
- States: IDLE, COLLECT, DONE, REFUND. All outputs are registered. Pulses assert the cycle after the causing input.
- IDLE:
  - start=1 latches cost, clears paid and the per-transaction coin counts, and goes to COLLECT. If cost==0, go to DONE instead.
  - coin_valid and cancel are ignored in IDLE.
  - disp_valid decrements the matching counter, saturating at 0. An illegal disp_coin (not 1/2/5) is ignored.
  - A disp_valid in the same cycle as start is still applied.
- COLLECT, priority order cancel > coin_valid > timeout:
  - cancel: go to REFUND. A coin presented in the same cycle is rejected.
  - coin_valid: accept iff coin_type != 00, the type count < INV_MAX, and paid+value <= 2^AMT_W-1 (no wrap).
  - Accept: paid += value, inventory++ and per-transaction count++, coin_accept pulse. If new paid >= cost, go to DONE.
  - Otherwise: coin_reject pulse, with no state change except a timeout counter reset.
  - Timeout counter: increments each COLLECT cycle without coin_valid; clears on any coin_valid. When it reaches TIMEOUT, go to REFUND.
- DONE: done pulse for one cycle, then IDLE. paid holds until the next start; the change logic computes paid-cost.
- REFUND:
  - refund pulse for one cycle, with paid still showing the amount to return.
  - Inventory is decremented by the per-transaction counts, so it returns to its pre-transaction state.
  - Next state is IDLE, with paid unchanged until the next start.
- cough_up_more = (state==COLLECT) && paid < cost.
- No arithmetic result may wrap; all compares are unsigned AMT_W-bit.

Test Plan:
- cost=7; insert quarter then dime -> accept,accept; paid=5 then 7; done pulse; quarters=1, dimes=1; cough_up_more 1 then 0.
- cost=3; insert 00, then nickel x3 -> reject then 3 accepts; done after third; nickels=3. Next transaction with cost=2: nickel rejected (full), dime accepted.
- cost=15; quarter x3 then nickel -> paid=15 after the three quarters, done. Separately, paid=14 plus a quarter is rejected (no overflow).
- cost=9; dime, then cancel together with coin_valid=quarter -> quarter rejected; refund with paid=2; dimes returns to its prior value.
- cost=4; no coins for 15 cycles -> refund with paid=0 on cycle 16; a coin_valid at cycle 10 restarts the count.
- quarters=2 in IDLE; disp_valid with disp_coin=5 x3 -> quarters 1, 0, 0 (saturates). disp_valid ignored in COLLECT. rst mid-COLLECT -> all outputs 0 next cycle.
